// File: rtl/deadtime_gen.sv
// Three-phase complementary gate driver with programmable dead time on every transition,
// global enable and a sticky fault shutdown. All outputs come straight from registers.
module deadtime_gen #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                pwmA_in,
    input  logic                pwmB_in,
    input  logic                pwmC_in,
    input  logic [DT_WIDTH-1:0] dead_cycles,
    input  logic                enable,
    input  logic                fault_in,
    input  logic                fault_clr,
    output logic                gateA_hi,
    output logic                gateA_lo,
    output logic                gateB_hi,
    output logic                gateB_lo,
    output logic                gateC_hi,
    output logic                gateC_lo,
    output logic                fault_latched,
    output logic                busy
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_LO_ON = 3'd1,
        ST_DT_HI = 3'd2,
        ST_HI_ON = 3'd3,
        ST_DT_LO = 3'd4
    } phase_t;

    logic [2:0]          pwm_s;
    logic [DT_WIDTH-1:0] load_s;
    logic                hold_off_s;
    logic                fault_nxt_s;
    phase_t              state_r     [3];
    phase_t              state_nxt_s [3];
    logic [DT_WIDTH-1:0] cnt_r       [3];
    logic [DT_WIDTH-1:0] cnt_nxt_s   [3];
    logic [2:0]          hi_nxt_s;
    logic [2:0]          lo_nxt_s;
    logic [2:0]          dt_nxt_s;
    logic [2:0]          gate_hi_r;
    logic [2:0]          gate_lo_r;
    logic                fault_r;
    logic                busy_r;

    assign pwm_s = {pwmC_in, pwmB_in, pwmA_in};

    // Dead-time reload value (a zero setting behaves as one cycle) and fault bookkeeping
    always_comb begin
        if (dead_cycles == {DT_WIDTH{1'b0}}) begin
            load_s = {DT_WIDTH{1'b0}};
        end else begin
            load_s = dead_cycles - DT_WIDTH'(1);
        end
        hold_off_s = fault_in | fault_r | ~enable;
        if (fault_in) begin
            fault_nxt_s = 1'b1;
        end else if (fault_clr) begin
            fault_nxt_s = 1'b0;
        end else begin
            fault_nxt_s = fault_r;
        end
    end

    // Per-phase next state; gate levels are decoded from the next state so they register with it
    always_comb begin
        hi_nxt_s = 3'b000;
        lo_nxt_s = 3'b000;
        dt_nxt_s = 3'b000;
        for (int p = 0; p < 3; p++) begin
            state_nxt_s[p] = state_r[p];
            cnt_nxt_s[p]   = {DT_WIDTH{1'b0}};
            if (hold_off_s) begin
                state_nxt_s[p] = ST_OFF;
            end else begin
                case (state_r[p])
                    ST_OFF: state_nxt_s[p] = ST_LO_ON;
                    ST_LO_ON: begin
                        if (pwm_s[p]) begin
                            state_nxt_s[p] = ST_DT_HI;
                            cnt_nxt_s[p]   = load_s;
                        end else begin
                            state_nxt_s[p] = ST_LO_ON;
                        end
                    end
                    ST_DT_HI: begin
                        if (!pwm_s[p]) begin
                            state_nxt_s[p] = ST_LO_ON;
                        end else if (cnt_r[p] == {DT_WIDTH{1'b0}}) begin
                            state_nxt_s[p] = ST_HI_ON;
                        end else begin
                            state_nxt_s[p] = ST_DT_HI;
                            cnt_nxt_s[p]   = cnt_r[p] - DT_WIDTH'(1);
                        end
                    end
                    ST_HI_ON: begin
                        if (!pwm_s[p]) begin
                            state_nxt_s[p] = ST_DT_LO;
                            cnt_nxt_s[p]   = load_s;
                        end else begin
                            state_nxt_s[p] = ST_HI_ON;
                        end
                    end
                    ST_DT_LO: begin
                        if (pwm_s[p]) begin
                            state_nxt_s[p] = ST_HI_ON;
                        end else if (cnt_r[p] == {DT_WIDTH{1'b0}}) begin
                            state_nxt_s[p] = ST_LO_ON;
                        end else begin
                            state_nxt_s[p] = ST_DT_LO;
                            cnt_nxt_s[p]   = cnt_r[p] - DT_WIDTH'(1);
                        end
                    end
                    default: state_nxt_s[p] = ST_OFF;
                endcase
            end
            hi_nxt_s[p] = (state_nxt_s[p] == ST_HI_ON);
            lo_nxt_s[p] = (state_nxt_s[p] == ST_LO_ON);
            dt_nxt_s[p] = (state_nxt_s[p] == ST_DT_HI) || (state_nxt_s[p] == ST_DT_LO);
        end
    end

    // State, counters, gate drives and flags
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int p = 0; p < 3; p++) begin
                state_r[p] <= ST_OFF;
                cnt_r[p]   <= {DT_WIDTH{1'b0}};
            end
            gate_hi_r <= 3'b000;
            gate_lo_r <= 3'b000;
            fault_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                state_r[p] <= state_nxt_s[p];
                cnt_r[p]   <= cnt_nxt_s[p];
            end
            gate_hi_r <= hi_nxt_s;
            gate_lo_r <= lo_nxt_s;
            fault_r   <= fault_nxt_s;
            busy_r    <= |dt_nxt_s;
        end
    end

    assign gateA_hi      = gate_hi_r[0];
    assign gateA_lo      = gate_lo_r[0];
    assign gateB_hi      = gate_hi_r[1];
    assign gateB_lo      = gate_lo_r[1];
    assign gateC_hi      = gate_hi_r[2];
    assign gateC_lo      = gate_lo_r[2];
    assign fault_latched = fault_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_deadtime_gen.sv
// Bench for deadtime_gen: directed scenarios plus a long random run, every cycle compared
// against a timeline model (which side is on, and at which cycle a pending side turns on).
module tb_deadtime_gen;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic [2:0] pwm = 3'b000;
    logic [7:0] dead_cycles = 8'd0;
    logic       enable = 1'b0;
    logic       fault_in = 1'b0;
    logic       fault_clr = 1'b0;
    logic       gateA_hi, gateA_lo, gateB_hi, gateB_lo, gateC_hi, gateC_lo;
    logic       fault_latched, busy;

    int n_vec = 0;
    int n_err = 0;

    // model: side 0=none,1=low,2=high; on_at = cycle at which tgt side turns on (-1 = no gap)
    int side [3];
    int tgt [3];
    int on_at [3];
    bit m_flt;
    int cyc;

    // independent gap-length monitor
    int prev_side [3];
    int gap_len [3];
    int gap_d [3];
    bit clean [3];

    deadtime_gen #(.DT_WIDTH(8)) dut (
        .clk(clk), .rstb(rstb),
        .pwmA_in(pwm[0]), .pwmB_in(pwm[1]), .pwmC_in(pwm[2]),
        .dead_cycles(dead_cycles), .enable(enable),
        .fault_in(fault_in), .fault_clr(fault_clr),
        .gateA_hi(gateA_hi), .gateA_lo(gateA_lo),
        .gateB_hi(gateB_hi), .gateB_lo(gateB_lo),
        .gateC_hi(gateC_hi), .gateC_lo(gateC_lo),
        .fault_latched(fault_latched), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 3; p++) begin
            side[p] = 0; tgt[p] = 0; on_at[p] = -1;
            prev_side[p] = 0; gap_len[p] = 0; gap_d[p] = 1; clean[p] = 1'b0;
        end
        m_flt = 1'b0;
    endtask

    task automatic model_edge();
        bit force_off;
        int d;
        int want;
        force_off = fault_in || m_flt || !enable;
        d = (dead_cycles == 8'd0) ? 1 : int'(dead_cycles);
        cyc++;
        for (int p = 0; p < 3; p++) begin
            want = pwm[p] ? 2 : 1;
            if (force_off) begin
                side[p] = 0; on_at[p] = -1;
            end else if (on_at[p] >= 0) begin
                if (want != tgt[p]) begin
                    side[p] = want; on_at[p] = -1;
                end else if (cyc == on_at[p]) begin
                    side[p] = tgt[p]; on_at[p] = -1;
                end
            end else if (side[p] == 0) begin
                side[p] = 1;
            end else if (side[p] != want) begin
                side[p] = 0; tgt[p] = want; on_at[p] = cyc + d;
            end
        end
        m_flt = fault_in ? 1'b1 : (fault_clr ? 1'b0 : m_flt);
    endtask

    task automatic compare_outputs();
        logic [2:0] hi_o, lo_o, hi_e, lo_e;
        bit busy_e;
        int s;
        hi_o = {gateC_hi, gateB_hi, gateA_hi};
        lo_o = {gateC_lo, gateB_lo, gateA_lo};
        busy_e = 1'b0;
        for (int p = 0; p < 3; p++) begin
            hi_e[p] = (side[p] == 2);
            lo_e[p] = (side[p] == 1);
            if (on_at[p] >= 0) busy_e = 1'b1;
        end
        check_value("gates_hi", 32'(hi_o), 32'(hi_e));
        check_value("gates_lo", 32'(lo_o), 32'(lo_e));
        check_value("fault_latched", 32'(fault_latched), 32'(m_flt));
        check_value("busy", 32'(busy), 32'(busy_e));
        check_value("overlap", 32'(hi_o & lo_o), 32'd0);
        for (int p = 0; p < 3; p++) begin
            s = hi_o[p] ? 2 : (lo_o[p] ? 1 : 0);
            if (s == 0) begin
                if (gap_len[p] == 0) begin
                    gap_d[p] = (dead_cycles == 8'd0) ? 1 : int'(dead_cycles);
                    clean[p] = 1'b1;
                end
                gap_len[p]++;
                if (!enable || fault_in || fault_latched) clean[p] = 1'b0;
            end else begin
                if (gap_len[p] > 0 && clean[p] && prev_side[p] != 0 && s != prev_side[p])
                    check_value("gap_len", 32'(gap_len[p] >= gap_d[p]), 32'd1);
                prev_side[p] = s;
                gap_len[p] = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    initial begin
        cyc = 0;
        model_reset();
        #12;
        check_value("rst_gates", 32'({gateA_hi, gateA_lo, gateB_hi, gateB_lo, gateC_hi, gateC_lo}), 32'd0);
        check_value("rst_flags", 32'({fault_latched, busy}), 32'd0);
        @(negedge clk);
        rstb = 1'b1;

        // T1: bootstrap to low side
        enable = 1'b1; dead_cycles = 8'd5;
        step();
        check_value("t1_lo", 32'(gateA_lo), 32'd1);
        check_value("t1_hi", 32'(gateA_hi), 32'd0);
        check_value("t1_busy", 32'(busy), 32'd0);

        // T2: 5-cycle dead time; a mid-interval dead_cycles change is ignored
        pwm[0] = 1'b1;
        step();
        check_value("t2_lo_fall", 32'(gateA_lo), 32'd0);
        dead_cycles = 8'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_value("t2_hi_wait", 32'({gateA_hi, busy}), 32'b01);
        end
        step();
        check_value("t2_hi_on", 32'({gateA_hi, gateA_lo, busy}), 32'b100);

        // T3: dead_cycles=0 gives a single-cycle gap
        dead_cycles = 8'd0;
        for (int i = 0; i < 4; i++) begin
            pwm[1] = ~pwm[1];
            step();
            check_value("t3_gap", 32'({gateB_hi, gateB_lo}), 32'd0);
            step();
            check_value("t3_on", 32'({gateB_hi, gateB_lo}), pwm[1] ? 32'b10 : 32'b01);
            step();
        end

        // T4: one-cycle glitch on C returns straight to low side
        dead_cycles = 8'd8;
        pwm[2] = 1'b1;
        step();
        pwm[2] = 1'b0;
        step();
        check_value("t4_back_lo", 32'({gateC_hi, gateC_lo}), 32'b01);
        for (int i = 0; i < 10; i++) begin
            step();
            check_value("t4_no_hi", 32'(gateC_hi), 32'd0);
        end

        // T5: fault from all-high, clear behaviour, restart through low side
        dead_cycles = 8'd2;
        pwm = 3'b111;
        for (int i = 0; i < 4; i++) step();
        check_value("t5_all_hi", 32'({gateC_hi, gateB_hi, gateA_hi}), 32'b111);
        fault_in = 1'b1;
        step();
        fault_in = 1'b0;
        check_value("t5_off", 32'({gateA_hi, gateA_lo, gateB_hi, gateB_lo, gateC_hi, gateC_lo}), 32'd0);
        check_value("t5_flt", 32'(fault_latched), 32'd1);
        step();
        check_value("t5_held", 32'(fault_latched), 32'd1);
        fault_in = 1'b1; fault_clr = 1'b1;
        step();
        check_value("t5_clr_ignored", 32'(fault_latched), 32'd1);
        fault_in = 1'b0;
        step();
        check_value("t5_clr", 32'(fault_latched), 32'd0);
        fault_clr = 1'b0;
        pwm = 3'b000;
        step();
        check_value("t5_resume_lo", 32'({gateC_lo, gateB_lo, gateA_lo}), 32'b111);

        // reset asserted mid-interval
        dead_cycles = 8'd6;
        pwm[0] = 1'b1;
        step();
        step();
        #2;
        rstb = 1'b0;
        #1;
        check_value("mid_rst_gates", 32'({gateA_hi, gateA_lo, gateB_hi, gateB_lo, gateC_hi, gateC_lo}), 32'd0);
        check_value("mid_rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rstb = 1'b1;

        // T6: random run
        for (int i = 0; i < 10000; i++) begin
            for (int p = 0; p < 3; p++)
                if ($urandom_range(0, 7) == 0) pwm[p] = ~pwm[p];
            if ($urandom_range(0, 15) == 0) dead_cycles = 8'($urandom_range(0, 9));
            enable    = ($urandom_range(0, 299) != 0);
            fault_in  = ($urandom_range(0, 499) == 0);
            fault_clr = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
